// File: rtl/ice51_boot_ctrl_pkg.sv
// ice51_pkg -- shared definitions for the ICE51 boot controller.
//
// Holds the boot FSM state encoding and the default image size, address
// width and CPU release delay. The CSUM state only exists when the
// ICE51_BOOT_CSUM_EN macro is defined; its encoding is left unused otherwise.
package ice51_pkg;

    localparam int ICE51_MEM_SIZE  = 512;
    localparam int ICE51_ADDR_W    = 9;
    localparam int ICE51_RUN_DELAY = 16;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
`ifdef ICE51_BOOT_CSUM_EN
        ST_CSUM = 2'd1,
`endif
        ST_HOLD = 2'd2,
        ST_RUN  = 2'd3
    } boot_state_t;

endpackage

// File: rtl/ice51_boot_ctrl_if.sv
// ice51_boot_ctrl_if -- shared program-memory write port.
//
// Bundles the address / write-enable / write-data bus that the boot
// controller drives towards the program memory.
//   addr   ADDR_W  memory address
//   we     1       write enable, one write per cycle it is high
//   wdata  8       write data
// master: the side driving the port (boot controller)
// slave:  the memory side
interface ice51_boot_ctrl_if #(
    parameter int ADDR_W = ice51_pkg::ICE51_ADDR_W
);
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [7:0]        wdata;

    modport master (output addr, output we, output wdata);
    modport slave  (input  addr, input  we, input  wdata);
endinterface

// File: rtl/ice51_boot_ctrl.sv
// ice51_boot_ctrl -- UART program loader for the ICE51 CPU.
//
// Holds the CPU in reset while MEM_SIZE bytes received from the UART are
// written to program memory at consecutive addresses starting at 0, then
// waits RUN_DELAY idle cycles and hands the memory port to the CPU.
// Optional feature (macro ICE51_BOOT_CSUM_EN): after loading, an 8-bit
// modulo-256 sum of the image is sent once through the UART transmitter
// before the hold phase.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_rx_valid, i_rx_data     received UART byte strobe and data
//   i_cpu_addr/we/wdata       CPU memory port, passed through only in RUN
//   o_mem_addr/we/wdata       shared memory port
//   o_cpu_nrst, o_boot_done   CPU released / boot finished (both high in RUN)
//   o_tx_valid, o_tx_data     checksum byte strobe (tied 0 without the macro)
//   i_tx_busy                 UART transmitter busy
//
// Handshake: i_rx_valid is a one-cycle strobe with no back-pressure; a byte
// is taken on every cycle it is high in LOAD. o_tx_valid is a one-cycle
// strobe, issued only on a cycle after i_tx_busy was sampled low.
module ice51_boot_ctrl
    import ice51_pkg::*;
#(
    parameter int MEM_SIZE  = ICE51_MEM_SIZE,
    parameter int ADDR_W    = ICE51_ADDR_W,
    parameter int RUN_DELAY = ICE51_RUN_DELAY
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic              i_cpu_we,
    input  logic [7:0]        i_cpu_wdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_we,
    output logic [7:0]        o_mem_wdata,
    output logic              o_cpu_nrst,
    output logic              o_boot_done,
    output logic              o_tx_valid,
    output logic [7:0]        o_tx_data,
    input  logic              i_tx_busy
);

    localparam int CNT_W  = ADDR_W + 1;
    localparam int HOLD_W = (RUN_DELAY < 2) ? 1 : $clog2(RUN_DELAY + 1);
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(MEM_SIZE - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RUN_DELAY);

    boot_state_t       state;
    boot_state_t       state_nxt;
    logic [CNT_W-1:0]  byte_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_wdata;
    logic              accept;
    logic              last_accept;

    // LOAD exits on the final byte, so the counter never passes MEM_SIZE.
    assign accept      = (state == ST_LOAD) && i_rx_valid;
    assign last_accept = accept && (byte_cnt == LAST_BYTE);

    // ---------------- state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: begin
                if (last_accept) begin
`ifdef ICE51_BOOT_CSUM_EN
                    state_nxt = ST_CSUM;
`else
                    state_nxt = ST_HOLD;
`endif
                end
            end
`ifdef ICE51_BOOT_CSUM_EN
            ST_CSUM: begin
                if (!i_tx_busy) begin
                    state_nxt = ST_HOLD;
                end
            end
`endif
            // hold_cnt is 0 on the first HOLD cycle, so HOLD lasts
            // RUN_DELAY+1 cycles counted from the cycle the final write shows.
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN:  state_nxt = ST_RUN;
            default: state_nxt = ST_LOAD;
        endcase
    end

    // ---------------- loader datapath ----------------
    // The write for a byte is registered, so it appears on the clock after
    // the strobe; a byte coinciding with reset is dropped by reset priority.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            byte_cnt <= '0;
            hold_cnt <= '0;
            ld_we    <= 1'b0;
            ld_addr  <= '0;
            ld_wdata <= 8'h00;
        end else begin
            ld_we <= 1'b0;
            if (accept) begin
                ld_we    <= 1'b1;
                ld_addr  <= byte_cnt[ADDR_W-1:0];
                ld_wdata <= i_rx_data;
                byte_cnt <= byte_cnt + 1'b1;
            end
            if (state == ST_HOLD) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end
        end
    end

`ifdef ICE51_BOOT_CSUM_EN
    // ---------------- image checksum ----------------
    logic [7:0] csum;
    logic       tx_valid_q;
    logic [7:0] tx_data_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            csum       <= 8'h00;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
        end else begin
            tx_valid_q <= 1'b0;
            if (accept) begin
                csum <= csum + i_rx_data;
            end
            if ((state == ST_CSUM) && !i_tx_busy) begin
                tx_valid_q <= 1'b1;
                tx_data_q  <= csum;
            end
        end
    end

    assign o_tx_valid = tx_valid_q;
    assign o_tx_data  = tx_data_q;
`else
    logic unused_tx_busy;
    assign unused_tx_busy = i_tx_busy;
    assign o_tx_valid     = 1'b0;
    assign o_tx_data      = 8'h00;
`endif

    // ---------------- outputs / memory-port mux ----------------
    always_comb begin
        o_mem_addr  = ld_addr;
        o_mem_we    = ld_we;
        o_mem_wdata = ld_wdata;
        o_cpu_nrst  = 1'b0;
        o_boot_done = 1'b0;
        if (state == ST_RUN) begin
            o_mem_addr  = i_cpu_addr;
            o_mem_we    = i_cpu_we;
            o_mem_wdata = i_cpu_wdata;
            o_cpu_nrst  = 1'b1;
            o_boot_done = 1'b1;
        end
    end

endmodule

// File: doc/ice51_boot_ctrl.md
ICE51_BOOT_CTRL -- requirements
Module: ice51_boot_ctrl

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 512, the number of program bytes loaded before the CPU runs.
REQ-002 SHALL have parameter ADDR_W, default 9, the memory address width, with 2^ADDR_W >= MEM_SIZE.
REQ-003 SHALL have parameter RUN_DELAY, default 16, the idle cycles between the last memory write and CPU release.
REQ-004 SHALL have ports, one clock and one synchronous active-high reset, listed in this order:
- i_clk  in  1  sole clock
- i_rst  in  1  synchronous reset, active-high
- i_rx_valid  in  1  one-cycle strobe, received UART byte
- i_rx_data  in  8  received UART byte
- i_cpu_addr  in  ADDR_W  CPU memory address
- i_cpu_we  in  1  CPU write enable
- i_cpu_wdata  in  8  CPU write data
- o_mem_addr  out  ADDR_W  shared memory address
- o_mem_we  out  1  shared memory write enable
- o_mem_wdata  out  8  shared memory write data
- o_cpu_nrst  out  1  CPU reset, low holds the CPU in reset
- o_boot_done  out  1  high once in RUN
- o_tx_valid  out  1  checksum byte strobe (see Configuration)
- o_tx_data  out  8  checksum byte
- i_tx_busy  in  1  UART transmitter busy

Function
REQ-005 SHALL implement states LOAD, CSUM, HOLD and RUN. LOAD is entered from reset.
REQ-006 In LOAD, each i_rx_valid cycle SHALL produce a single-cycle write on the next clock: o_mem_we=1, o_mem_addr=byte count, o_mem_wdata=i_rx_data.
REQ-007 The byte counter SHALL be ADDR_W+1 bits wide and SHALL increment once per accepted byte.
REQ-008 After the write of byte MEM_SIZE-1, the controller SHALL leave LOAD: to CSUM if BOOT_CSUM_EN is defined, otherwise to HOLD.
REQ-009 The counter SHALL never wrap. Bytes arriving outside LOAD SHALL be ignored with no memory write.
REQ-010 HOLD SHALL count exactly RUN_DELAY cycles and then enter RUN. With RUN_DELAY=0 it SHALL enter RUN on the next cycle.
REQ-011 In RUN, the CPU SHALL own the memory port: o_mem_addr, o_mem_we and o_mem_wdata SHALL equal the i_cpu_* inputs combinationally.
REQ-012 In RUN, o_cpu_nrst=1 and o_boot_done=1.
REQ-013 In every other state, o_cpu_nrst=0 and o_boot_done=0, and the CPU inputs SHALL never reach the memory port.
REQ-014 RUN SHALL be terminal until i_rst.
REQ-015 The memory write for a byte arriving on the same cycle as reset SHALL be discarded.

Reset
REQ-016 On i_rst=1 at a clock edge, the controller SHALL reset to:
- state LOAD, counter 0, checksum 0
- o_mem_we=0, o_mem_addr=0, o_mem_wdata=0
- o_cpu_nrst=0, o_boot_done=0
- o_tx_valid=0, o_tx_data=0
REQ-017 Reset asserted during any state, including mid-load or RUN, SHALL restart loading at address 0 and re-hold the CPU in reset on the same edge.

Configuration
REQ-018 With macro ICE51_BOOT_CSUM_EN defined, the controller SHALL keep an 8-bit modulo-256 sum of the loaded bytes.
REQ-019 In CSUM it SHALL wait while i_tx_busy=1, then pulse o_tx_valid for one cycle with o_tx_data=sum, then enter HOLD.
REQ-020 Without ICE51_BOOT_CSUM_EN, there SHALL be no CSUM state and no sum register, and o_tx_valid and o_tx_data SHALL be tied 0.

Structure
REQ-021 The shared package ice51_pkg SHALL hold the boot state encoding, the default MEM_SIZE and the default RUN_DELAY.
REQ-022 The block SHALL be a single module with no sub-module. The memory-port mux is inline.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset, then 512 bytes 0x00..0xFF twice -> 512 writes at addr 0..511 with matching data; o_cpu_nrst rises exactly RUN_DELAY+1 cycles after the last write (no CSUM).
- CSUM_EN, 512 bytes all 0x01 -> one o_tx_valid pulse, data 0x00; with i_tx_busy held high for 100 cycles, the pulse occurs only after busy falls.
- Reset after 200 bytes, then 512 more bytes -> first post-reset write at addr 0; the CPU stays in reset throughout.
- In RUN: i_cpu_we=1, addr 0x1A5, data 0x3C -> identical on o_mem_* the same cycle; extra i_rx_valid bytes -> no effect.
- Before RUN: i_cpu_we=1 pulses -> o_mem_we stays 0 except on loader writes.
- RUN_DELAY=0 -> RUN on the cycle after the final write (CSUM disabled).
